// File: rtl/prog_loader_if.sv
// Boot-loader signal bundle: UART byte input and CPU halt in, memory write port
// and CPU/status controls out. The loader sits on the master side.
interface prog_loader_if #(
    parameter int DataWidth = 16,
    parameter int AddrWidth = 8
);
    logic [7:0]           rx_data;
    logic                 rx_valid;
    logic                 cpu_halt;
    logic                 mem_wr;
    logic [AddrWidth-1:0] mem_addr;
    logic [DataWidth-1:0] mem_data;
    logic                 cpu_reset;
    logic                 busy;
    logic                 loaded;
    logic                 error;

    modport master (
        input  rx_data, rx_valid, cpu_halt,
        output mem_wr, mem_addr, mem_data, cpu_reset, busy, loaded, error
    );

    modport slave (
        output rx_data, rx_valid, cpu_halt,
        input  mem_wr, mem_addr, mem_data, cpu_reset, busy, loaded, error
    );
endinterface

// File: rtl/prog_loader.sv
// Boot loader: assembles a UART byte stream into 16-bit words, writes them from
// address 0, verifies an 8-bit checksum, then releases the CPU until it halts.
module prog_loader #(
    parameter int DataWidth = 16,
    parameter int AddrWidth = 8
) (
    input  logic          clk,
    input  logic          rst,
    prog_loader_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA_HI,
        S_DATA_LO,
        S_WRITE,
        S_CHECK,
        S_RUN,
        S_ERROR
    } state_e;

    state_e               state_q;
    logic [AddrWidth-1:0] count_q;
    logic [AddrWidth-1:0] addr_q;
    logic [DataWidth-1:0] data_q;
    logic [7:0]           sum_q;
    logic                 mem_wr_q;
    logic                 cpu_reset_q;
    logic                 busy_q;
    logic                 loaded_q;
    logic                 error_q;
    logic                 halt_q;

    logic [7:0] chk_total;
    assign chk_total = sum_q + bus.rx_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            sum_q       <= '0;
            mem_wr_q    <= 1'b0;
            cpu_reset_q <= 1'b0;
            busy_q      <= 1'b0;
            loaded_q    <= 1'b0;
            error_q     <= 1'b0;
            halt_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking everywhere here, so every branch sees the
            // pre-edge values; the default below makes mem_wr a one-cycle pulse.
            mem_wr_q <= 1'b0;
            halt_q   <= bus.cpu_halt;

            case (state_q)
                S_IDLE: begin
                    if (bus.rx_valid) begin
                        count_q  <= AddrWidth'(bus.rx_data);
                        addr_q   <= '0;
                        sum_q    <= '0;
                        busy_q   <= 1'b1;
                        loaded_q <= 1'b0;
                        state_q  <= S_DATA_HI;
                    end
                end

                S_DATA_HI: begin
                    if (bus.rx_valid) begin
                        data_q[DataWidth-1:8] <= bus.rx_data;
                        sum_q                 <= sum_q + bus.rx_data;
                        state_q               <= S_DATA_LO;
                    end
                end

                S_DATA_LO: begin
                    if (bus.rx_valid) begin
                        data_q[7:0] <= bus.rx_data;
                        sum_q       <= sum_q + bus.rx_data;
                        mem_wr_q    <= 1'b1;
                        state_q     <= S_WRITE;
                    end
                end

                S_WRITE: begin
                    // The write is already on the bus this cycle; a strobe here
                    // is a spacing violation but does not cancel it.
                    if (bus.rx_valid) begin
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_ERROR;
                    end else if (addr_q == count_q) begin
                        state_q <= S_CHECK;
                    end else begin
                        addr_q  <= addr_q + 1'b1;
                        state_q <= S_DATA_HI;
                    end
                end

                S_CHECK: begin
                    if (bus.rx_valid) begin
                        busy_q <= 1'b0;
                        if (chk_total == 8'd0) begin
                            cpu_reset_q <= 1'b1;
                            loaded_q    <= 1'b1;
                            state_q     <= S_RUN;
                        end else begin
                            error_q <= 1'b1;
                            state_q <= S_ERROR;
                        end
                    end
                end

                S_RUN: begin
                    if (bus.cpu_halt && !halt_q) begin
                        cpu_reset_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end

                S_ERROR: begin
                    cpu_reset_q <= 1'b0;
                    busy_q      <= 1'b0;
                    error_q     <= 1'b1;
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_data  = data_q;
    assign bus.cpu_reset = cpu_reset_q;
    assign bus.busy      = busy_q;
    assign bus.loaded    = loaded_q;
    assign bus.error     = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed scenarios plus random images
// scored against an arithmetic model of the image format.
module tb_prog_loader;

    typedef logic [15:0] word_q_t[$];
    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prog_loader_if #(.DataWidth(16), .AddrWidth(8)) bus ();
    prog_loader #(.DataWidth(16), .AddrWidth(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    int  n_tests  = 0;
    int  n_failed = 0;
    wr_t wr_q[$];
    int  wr_double = 0;
    logic wr_prev  = 1'b0;

    // Write monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.mem_wr === 1'b1) begin
            wr_q.push_back({bus.mem_addr, bus.mem_data});
            if (wr_prev) wr_double <= wr_double + 1;
        end
        wr_prev <= (bus.mem_wr === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Flags packed as {cpu_reset, busy, loaded, error}.
    task automatic check_flags(input string tag, input logic [3:0] exp);
        check(tag, {28'd0, bus.cpu_reset, bus.busy, bus.loaded, bus.error}, {28'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
        repeat (gap - 1) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Checksum byte that makes (sum of data bytes + chk) mod 256 == 0.
    function automatic logic [7:0] chk_for(input word_q_t words);
        int s = 0;
        foreach (words[i]) s += int'(words[i][15:8]) + int'(words[i][7:0]);
        return 8'((256 - (s % 256)) % 256);
    endfunction

    function automatic word_q_t rand_words(input int n);
        word_q_t w;
        for (int i = 0; i < n; i++) w.push_back(16'($urandom));
        return w;
    endfunction

    // COUNT byte and data bytes; the caller sends the checksum.
    task automatic send_body(input word_q_t words, input int max_gap);
        send_byte(8'(words.size() - 1), 2);
        foreach (words[i]) begin
            send_byte(words[i][15:8], int'($urandom_range(max_gap, 2)));
            send_byte(words[i][7:0], int'($urandom_range(max_gap, 2)));
        end
    endtask

    task automatic check_writes(input string tag, input word_q_t words);
        check({tag, "_nwr"}, wr_q.size(), words.size());
        for (int i = 0; i < words.size(); i++) begin
            if (i < wr_q.size()) begin
                check($sformatf("%s_addr%0d", tag, i), {24'd0, wr_q[i].addr}, i);
                check($sformatf("%s_data%0d", tag, i), {16'd0, wr_q[i].data}, {16'd0, words[i]});
            end
        end
    endtask

    initial begin
        word_q_t w;
        logic [7:0] chk;
        bit good;
        int nw;

        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.cpu_halt = 1'b0;
        repeat (2) tick();
        check_flags("reset_flags", 4'b0000);
        check("reset_mem_wr", {31'd0, bus.mem_wr}, 0);
        check("reset_mem_addr", {24'd0, bus.mem_addr}, 0);
        check("reset_mem_data", {16'd0, bus.mem_data}, 0);
        rst = 1'b0;
        tick();

        // Two-word image with good checksum.
        wr_q.delete();
        w = '{16'h1234, 16'h5678};
        send_body(w, 3);
        check_flags("t1_pre_chk", 4'b0100);
        send_byte(8'hEC, 1);
        check_flags("t1_run", 4'b1010);
        tick();
        check_writes("t1", w);

        // Halt edge returns to idle; second image reloads.
        bus.cpu_halt = 1'b1;
        tick();
        check_flags("t2_halt", 4'b0010);
        bus.cpu_halt = 1'b0;
        tick();
        wr_q.delete();
        w = '{16'hABCD};
        send_body(w, 2);
        check_flags("t2_pre_chk", 4'b0100);
        send_byte(8'h88, 1);
        check_flags("t2_run", 4'b1010);
        tick();
        check_writes("t2", w);

        // Halt already high when the CPU is released: no edge, no action.
        bus.cpu_halt = 1'b1;
        tick();
        w = rand_words(2);
        send_body(w, 3);
        send_byte(chk_for(w), 1);
        repeat (3) tick();
        check_flags("t3_halt_level", 4'b1010);
        bus.cpu_halt = 1'b0;
        tick();
        bus.cpu_halt = 1'b1;
        tick();
        check("t3_halt_edge", {31'd0, bus.cpu_reset}, 0);
        bus.cpu_halt = 1'b0;

        // Bad checksum is sticky; later bytes cause no writes.
        do_reset();
        wr_q.delete();
        w = '{16'h1234, 16'h5678};
        send_body(w, 2);
        send_byte(8'hED, 1);
        check_flags("t4_err", 4'b0001);
        tick();
        check_writes("t4", w);
        repeat (6) send_byte(8'($urandom), 2);
        check("t4_no_more_wr", wr_q.size(), 2);
        check_flags("t4_err_hold", 4'b0001);

        // Asynchronous reset mid-load, then a clean load from address 0.
        do_reset();
        send_byte(8'h03, 2);
        send_byte(8'h11, 2);
        check_flags("t5_busy", 4'b0100);
        rst = 1'b1;
        #1;
        check_flags("t5_async_flags", 4'b0000);
        check("t5_async_addr", {24'd0, bus.mem_addr}, 0);
        check("t5_async_data", {16'd0, bus.mem_data}, 0);
        tick();
        rst = 1'b0;
        tick();
        wr_q.delete();
        w = rand_words(2);
        send_body(w, 4);
        send_byte(chk_for(w), 1);
        check_flags("t5_reload", 4'b1010);
        tick();
        check_writes("t5", w);

        // Strobe landing in the write cycle: write survives, error set.
        do_reset();
        wr_q.delete();
        send_byte(8'h00, 2);
        send_byte(8'hAA, 2);
        send_byte(8'hBB, 1);
        send_byte(8'hCC, 2);
        check_flags("t6_err", 4'b0001);
        w = '{16'hAABB};
        check_writes("t6", w);

        // Full 256-word image.
        do_reset();
        wr_q.delete();
        w = rand_words(256);
        send_body(w, 2);
        send_byte(chk_for(w), 1);
        check_flags("t7_run", 4'b1010);
        repeat (3) tick();
        check_writes("t7", w);

        // Random images, good or corrupted checksum.
        for (int it = 0; it < 8; it++) begin
            do_reset();
            wr_q.delete();
            nw   = int'($urandom_range(16, 1));
            w    = rand_words(nw);
            good = 1'($urandom_range(1, 0));
            chk  = chk_for(w) + (good ? 8'd0 : 8'($urandom_range(255, 1)));
            send_body(w, 4);
            send_byte(chk, 1);
            check_flags($sformatf("r%0d_flags", it), good ? 4'b1010 : 4'b0001);
            tick();
            check_writes($sformatf("r%0d", it), w);
            if (good) begin
                repeat (int'($urandom_range(3, 0))) tick();
                bus.cpu_halt = 1'b1;
                tick();
                check($sformatf("r%0d_halt", it), {31'd0, bus.cpu_reset}, 0);
                bus.cpu_halt = 1'b0;
            end
        end

        check("single_cycle_wr", wr_double, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
